// File: rtl/prom_fetch_arbiter.sv
// Two-port arbiter in front of a single-port program ROM with a registered read.
// Serves byte or big-endian word fetches, one transaction in flight at a time.
module prom_fetch_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_req0,
    input  logic [ADDR_W-1:0]   i_addr0,
    input  logic                i_wide0,
    output logic                o_gnt0,
    output logic                o_valid0,
    output logic [2*DATA_W-1:0] o_data0,
    input  logic                i_req1,
    input  logic [ADDR_W-1:0]   i_addr1,
    input  logic                i_wide1,
    output logic                o_gnt1,
    output logic                o_valid1,
    output logic [2*DATA_W-1:0] o_data1,
    output logic [ADDR_W-1:0]   o_rom_ad,
    output logic                o_rom_ce,
    input  logic [DATA_W-1:0]   i_rom_dout,
    output logic                o_busy
);

    typedef enum logic [1:0] {IDLE, RD0, RD1, RD2} state_t;

    state_t                state, state_nxt;
    logic                  take;
    logic                  win;
    logic [ADDR_W-1:0]     sel_addr;
    logic                  sel_wide;

    logic [ADDR_W-1:0]     addr_q;
    logic                  wide_q;
    logic                  port_q;
    logic                  last_q;     // port granted most recently
    logic [DATA_W-1:0]     hi_q;
    logic [ADDR_W-1:0]     rom_ad_q;
    logic                  rom_ce_q;
    logic [1:0]            gnt_q;
    logic [1:0]            valid_q;
    logic [2*DATA_W-1:0]   data0_q;
    logic [2*DATA_W-1:0]   data1_q;
    logic                  deliver;
    logic [2*DATA_W-1:0]   result;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        win       = 1'b0;
        deliver   = 1'b0;
        result    = {i_rom_dout, {DATA_W{1'b0}}} >> DATA_W;
        case (state)
            IDLE: begin
                if (i_req0 || i_req1) begin
                    take      = 1'b1;
                    state_nxt = RD0;
                    if (i_req0 && i_req1) win = FIXED_PRIO ? 1'b0 : ~last_q;
                    else                  win = ~i_req0;
                end
            end
            RD0: state_nxt = RD1;
            RD1: begin
                if (wide_q) begin
                    state_nxt = RD2;
                end else begin
                    state_nxt = IDLE;
                    deliver   = 1'b1;
                end
            end
            RD2: begin
                state_nxt = IDLE;
                deliver   = 1'b1;
                result    = {hi_q, i_rom_dout};
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sel_addr = win ? i_addr1 : i_addr0;
    assign sel_wide = win ? i_wide1 : i_wide0;

    // Outputs are registered so the ROM sees a clean address/enable each cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q   <= '0;
            wide_q   <= 1'b0;
            port_q   <= 1'b0;
            last_q   <= 1'b1;
            hi_q     <= '0;
            rom_ad_q <= '0;
            rom_ce_q <= 1'b0;
            gnt_q    <= '0;
            valid_q  <= '0;
            data0_q  <= '0;
            data1_q  <= '0;
        end else begin
            gnt_q    <= '0;
            valid_q  <= '0;
            rom_ce_q <= 1'b0;
            if (take) begin
                addr_q      <= sel_addr;
                wide_q      <= sel_wide;
                port_q      <= win;
                last_q      <= win;
                gnt_q[win]  <= 1'b1;
                rom_ad_q    <= sel_addr;
                rom_ce_q    <= 1'b1;
            end
            if (state == RD0 && wide_q) begin
                rom_ad_q <= addr_q + ADDR_W'(1);
                rom_ce_q <= 1'b1;
            end
            if (state == RD1 && wide_q) hi_q <= i_rom_dout;
            if (deliver) begin
                valid_q[port_q] <= 1'b1;
                if (port_q) data1_q <= result;
                else        data0_q <= result;
            end
        end
    end

    assign o_gnt0   = gnt_q[0];
    assign o_gnt1   = gnt_q[1];
    assign o_valid0 = valid_q[0];
    assign o_valid1 = valid_q[1];
    assign o_data0  = data0_q;
    assign o_data1  = data1_q;
    assign o_rom_ad = rom_ad_q;
    assign o_rom_ce = rom_ce_q;
    assign o_busy   = (state != IDLE);

endmodule

// File: tb/tb_prom_fetch_arbiter.sv
// Scoreboard bench for prom_fetch_arbiter: drivers push expected results, a
// negedge monitor checks grants, ROM addressing, latency and returned data.
module tb_prom_fetch_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 0, req1 = 0, wide0 = 0, wide1 = 0;
    logic [11:0] addr0 = '0, addr1 = '0;
    logic        gnt0, gnt1, valid0, valid1, rom_ce, busy;
    logic [15:0] data0, data1;
    logic [11:0] rom_ad;
    logic [7:0]  rom_dout;
    logic        f_gnt0, f_gnt1, f_valid0, f_valid1, f_rom_ce, f_busy;
    logic [15:0] f_data0, f_data1;
    logic [11:0] f_rom_ad;
    logic [7:0]  f_rom_dout;

    always #5 clk = ~clk;

    prom_fetch_arbiter #(.ADDR_W(12), .DATA_W(8), .FIXED_PRIO(1'b0)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0(req0), .i_addr0(addr0), .i_wide0(wide0),
        .o_gnt0(gnt0), .o_valid0(valid0), .o_data0(data0),
        .i_req1(req1), .i_addr1(addr1), .i_wide1(wide1),
        .o_gnt1(gnt1), .o_valid1(valid1), .o_data1(data1),
        .o_rom_ad(rom_ad), .o_rom_ce(rom_ce), .i_rom_dout(rom_dout), .o_busy(busy));

    prom_fetch_arbiter #(.ADDR_W(12), .DATA_W(8), .FIXED_PRIO(1'b1)) dut_fp (
        .i_clk(clk), .i_rst(rst),
        .i_req0(req0), .i_addr0(addr0), .i_wide0(wide0),
        .o_gnt0(f_gnt0), .o_valid0(f_valid0), .o_data0(f_data0),
        .i_req1(req1), .i_addr1(addr1), .i_wide1(wide1),
        .o_gnt1(f_gnt1), .o_valid1(f_valid1), .o_data1(f_data1),
        .o_rom_ad(f_rom_ad), .o_rom_ce(f_rom_ce), .i_rom_dout(f_rom_dout), .o_busy(f_busy));

    function automatic logic [7:0] romf(input logic [11:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [15:0] expv(input logic [11:0] a, input logic w);
        logic [11:0] n;
        n = a + 12'd1;
        return w ? {romf(a), romf(n)} : {8'h00, romf(a)};
    endfunction

    always @(posedge clk) begin
        if (rom_ce)   rom_dout   <= romf(rom_ad);
        if (f_rom_ce) f_rom_dout <= romf(f_rom_ad);
    end

    int tests = 0, fails = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [15:0] q0[$], q1[$];
    logic [11:0] cur_addr[2];
    logic        cur_wide[2];
    logic [15:0] last_d[2];

    // Monitor: reference is the behavioural rules (who may win, when ROM
    // addresses appear, how many cycles until the result, what it holds).
    int          last = 1, gcyc = 0, p = 0;
    logic        pr0 = 0, pr1 = 0, pend = 0, pwide = 0;
    int          pport = 0;
    logic [11:0] paddr = '0, nxt;
    logic [15:0] e;

    always @(negedge clk) begin
        if (rst) begin
            pend = 0;
            last = 1;
        end else begin
            if (valid0 || valid1) begin
                p = valid1 ? 1 : 0;
                chk("valid_excl", {31'd0, valid0 & valid1}, 0);
                chk("valid_pending", {31'd0, pend}, 1);
                chk("valid_port", p, pport);
                chk("valid_latency", cyc - gcyc, pwide ? 3 : 2);
                if ((p == 0 ? q0.size() : q1.size()) == 0) begin
                    chk("valid_unexpected", 1, 0);
                end else begin
                    e = (p == 0) ? q0.pop_front() : q1.pop_front();
                    chk(p == 0 ? "data0" : "data1", p == 0 ? data0 : data1, e);
                end
                last_d[p] = p == 0 ? data0 : data1;
                pend = 0;
            end else if (pend && cyc > gcyc + 3) begin
                chk("valid_timeout", 1, 0);
                pend = 0;
            end
            if (gnt0 || gnt1) begin
                p = gnt1 ? 1 : 0;
                chk("gnt_excl", {31'd0, gnt0 & gnt1}, 0);
                chk("gnt_while_busy", {31'd0, pend}, 0);
                if (pr0 && pr1) chk("rr_winner", p, 1 - last);
                else            chk("lone_winner", p, pr1 ? 1 : 0);
                chk("rd0_ad", rom_ad, cur_addr[p]);
                chk("rd0_ce", rom_ce, 1);
                last = p; pend = 1; pport = p; gcyc = cyc;
                paddr = cur_addr[p]; pwide = cur_wide[p];
            end else if (pend && cyc == gcyc + 1) begin
                nxt = paddr + 12'd1;
                chk("rd1_ce", rom_ce, pwide);
                if (pwide) chk("rd1_ad", rom_ad, nxt);
            end
            pr0 = req0;
            pr1 = req1;
        end
    end

    task automatic push(input int pt, input logic [11:0] a, input logic w);
        if (pt == 0) q0.push_back(expv(a, w));
        else         q1.push_back(expv(a, w));
    endtask

    // Raise one request, wait (bounded) for its grant, then scramble the inputs.
    task automatic issue(input int pt, input logic [11:0] a, input logic w);
        bit seen = 0;
        cur_addr[pt] = a; cur_wide[pt] = w;
        push(pt, a, w);
        if (pt == 0) begin req0 = 1; addr0 = a; wide0 = w; end
        else         begin req1 = 1; addr1 = a; wide1 = w; end
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = (pt == 0) ? gnt0 : gnt1;
        end
        if (!seen) chk("gnt_timeout", pt, 99);
        @(posedge clk); #1;
        if (pt == 0) begin req0 = 0; addr0 = 12'($urandom); wide0 = 1'($urandom); end
        else         begin req1 = 0; addr1 = 12'($urandom); wide1 = 1'($urandom); end
    endtask

    task automatic do_reset();
        rst = 1; req0 = 0; req1 = 0;
        @(posedge clk); #1;
        rst = 0;
        q0.delete(); q1.delete();
    endtask

    int order[$];
    int fp0, fp1, g1a, g1b;

    initial begin
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt",   {gnt0, gnt1}, 0);
        chk("rst_valid", {valid0, valid1}, 0);
        chk("rst_ce",    rom_ce, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_ad",    rom_ad, 0);
        chk("rst_data",  {data0, data1}, 0);
        @(posedge clk); #1; rst = 0;

        issue(0, 12'h010, 1'b0); repeat (3) @(posedge clk); #1;
        chk("byte_010", last_d[0], 16'h004A);
        issue(1, 12'h123, 1'b1); repeat (3) @(posedge clk); #1;
        chk("word_123", last_d[1], 16'h797E);
        issue(0, 12'hFFF, 1'b1); repeat (3) @(posedge clk); #1;
        chk("wrap_fff", last_d[0], 16'hA55A);

        // Contention: both ports hold requests continuously after reset.
        do_reset();
        cur_addr[0] = 12'h040; cur_wide[0] = 0; cur_addr[1] = 12'h041; cur_wide[1] = 0;
        addr0 = 12'h040; wide0 = 0; addr1 = 12'h041; wide1 = 0;
        req0 = 1; req1 = 1; fp0 = 0; fp1 = 0; order.delete();
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            if (gnt0) begin order.push_back(0); push(0, 12'h040, 0); end
            if (gnt1) begin order.push_back(1); push(1, 12'h041, 0); end
            fp0 += f_gnt0; fp1 += f_gnt1;
        end
        #1 req0 = 0; req1 = 0;
        repeat (4) @(posedge clk); #1;
        chk("cont_count_ge4", order.size() >= 4, 1);
        foreach (order[i]) chk("cont_order", order[i], i % 2);
        chk("fp_port1_never", fp1, 0);
        chk("fp_port0_seen", fp0 > 0, 1);

        // Reset during RD1 of a word fetch aborts it.
        issue(1, 12'h200, 1'b1);
        rst = 1;
        @(posedge clk); #1; rst = 0; q1.delete();
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_ce", rom_ce, 0);
        repeat (3) begin
            chk("abort_valid", {valid0, valid1}, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        issue(0, 12'h0AB, 1'b1); repeat (3) @(posedge clk); #1;
        chk("after_abort", last_d[0], 16'hF1F6);

        // Persistent request on port 1: second grant three cycles after the first.
        cur_addr[1] = 12'h002; cur_wide[1] = 0; addr1 = 12'h002; wide1 = 0; req1 = 1;
        g1a = -1; g1b = -1;
        for (int k = 0; k < 15 && g1b < 0; k++) begin
            @(negedge clk);
            if (gnt1) begin
                push(1, 12'h002, 0);
                if (g1a < 0) g1a = cyc; else g1b = cyc;
            end
        end
        #1 req1 = 0;
        repeat (4) @(posedge clk); #1;
        chk("persist_spacing", g1b - g1a, 3);
        chk("persist_data", last_d[1], 16'h0058);

        // Randomized traffic on both ports.
        fork
            for (int n = 0; n < 40; n++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1 issue(0, 12'($urandom), 1'($urandom));
            end
            for (int n = 0; n < 40; n++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1 issue(1, 12'($urandom), 1'($urandom));
            end
        join
        repeat (6) @(posedge clk); #1;
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/prom_fetch_arbiter.md
Name: prom_fetch_arbiter

Overview:
Shares the single-port program ROM (12-bit address, 8-bit data, one-cycle registered read) between two requesters. Port 0 is the instruction fetch path; port 1 is the debug/display browse path driven by the button logic. Each request is either a byte or a big-endian 16-bit word built from two consecutive ROM bytes. The block sequences the ROM address/enable and returns the assembled result to the granted port with a one-cycle valid pulse.

Parameters:
ADDR_W, 12, ROM address width; all address arithmetic is modulo 2^ADDR_W
DATA_W, 8, ROM data width; result width is 2*DATA_W
FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins ties

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst  input  1  synchronous reset, active-high
i_req0  input  1  port 0 request; held until o_gnt0
i_addr0  input  ADDR_W  port 0 start address
i_wide0  input  1  port 0 size: 0 = byte, 1 = word
o_gnt0  output  1  one-cycle grant pulse to port 0
o_valid0  output  1  one-cycle result-valid pulse to port 0
o_data0  output  2*DATA_W  port 0 result
i_req1, i_addr1, i_wide1, o_gnt1, o_valid1, o_data1: same as port 0, for port 1
o_rom_ad  output  ADDR_W  ROM address
o_rom_ce  output  1  ROM clock enable
i_rom_dout  input  DATA_W  ROM data, valid one cycle after the address is sampled with ce=1
o_busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, active-high): state=IDLE, all o_gnt*/o_valid*/o_rom_ce/o_busy=0, o_data*=0, o_rom_ad=0, round-robin pointer set so port 0 wins the first tie. Reset mid-transaction aborts it: no o_valid, no further ROM access.
- States: IDLE, RD0, RD1, RD2.
- IDLE: samples i_req*. If any request is present, the rising edge that ends cycle C does all of the following:
  - choose the winner;
  - latch addr, wide and port;
  - go to RD0.
- Arbitration:
  - FIXED_PRIO=1: port 0 wins any tie.
  - FIXED_PRIO=0: a tie goes to the port not granted most recently; a lone request is always granted. The pointer updates only on grant.
- RD0 (cycle C+1): o_gnt of the winner=1, o_rom_ad=latched addr, o_rom_ce=1. Go to RD1.
- RD1 (cycle C+2): i_rom_dout holds byte[addr].
  - Byte request: capture it at end of cycle. In cycle C+3, o_data=the byte zero-extended into the low byte, o_valid=1, state=IDLE.
  - Word request: o_rom_ad=(addr+1) mod 2^ADDR_W, o_rom_ce=1, capture byte into the high byte, go to RD2.
- RD2 (cycle C+3, word only): i_rom_dout holds byte[addr+1]. Capture it into the low byte. In cycle C+4, o_data={hi,lo}, o_valid=1, state=IDLE.
- Latency from request-seen edge to o_valid: byte 3 cycles, word 4 cycles.
- Back-to-back: IDLE during a valid cycle may accept a new request, giving a sustained byte rate of 1 per 3 cycles.
- o_rom_ce=0 in IDLE and in RD1/RD2 when no address is issued. o_rom_ad holds its last value when not issuing.
- o_data of the non-served port holds its previous value. o_data of the served port holds its result until that port's next o_valid.
- Requester contract:
  - i_addr*/i_wide* are sampled only at the grant-decision edge.
  - After o_gnt the requester may change them or drop i_req.
  - A request still high after o_gnt is treated as a new request at the next IDLE.
  - A request dropped before the grant is lost; this is legal, with no error.
- o_gnt and o_valid are never high for both ports in the same cycle. At most one transaction is in flight.
- Word wrap: addr = all-ones reads the low byte from address 0.

Test Plan:
Bench ROM model: mem[a] = a[7:0] XOR 8'h5A, registered read.
- Byte fetch: port 0 req addr 12'h010, wide=0, in IDLE at edge E -> o_gnt0 in cycle E+1; o_rom_ad=12'h010 with ce=1; o_valid0 in cycle E+3 with o_data0=16'h004A.
- Word fetch: port 1 req addr 12'h123, wide=1 -> o_rom_ad 12'h123 then 12'h124 on consecutive cycles; o_valid1 at E+4 with o_data1=16'h797E.
- Wrap: port 0 word at 12'hFFF -> second address 12'h000; o_data0=16'hA55A.
- Contention: both ports request continuously, FIXED_PRIO=0, after reset -> grants in order 0,1,0,1 and never both in one cycle. With FIXED_PRIO=1 -> only port 0 is granted while it requests.
- Reset mid-word: assert i_rst during RD1 -> next cycle state IDLE, o_busy=0, no o_valid on either port, o_rom_ce=0; a new request then completes normally.
- Persistent req: port 1 keeps i_req1 high after o_gnt1 for byte addr 12'h002 -> second grant is issued in the cycle after o_valid1, i.e. a 3-cycle grant spacing.
